// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative multiply/divide unit for the EX stage.
//
// Executes MULT / MULTU / DIV / DIVU and leaves the result in the HI/LO pair:
//   multiply : {hi_o, lo_o} = 2*WIDTH-bit product
//   divide   : lo_o = quotient, hi_o = remainder (remainder takes dividend sign)
//
// The datapath works on operand magnitudes: multiply is shift-add (one
// multiplier bit per cycle), divide is restoring (one quotient bit per cycle).
// Signs are re-applied on the last iteration. A divide by zero bypasses the
// iteration and finishes in one cycle with hi_o = dividend, lo_o = all ones.
//
// Optional build macro:
//   MDU_FAST_MUL_EN  -- mult/multu form the full product combinationally in
//                       IDLE and go straight to DONE (ready_o one cycle after
//                       the start). Divide timing is unaffected.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start_i         request an operation (only sampled in IDLE)
//   op_i[1:0]       00 mult, 01 multu, 10 div, 11 divu
//   src_a_i         multiplicand / dividend
//   src_b_i         multiplier / divisor
//   annul_i         flush: back to IDLE, no ready_o, hi_o/lo_o untouched
//   busy_o          iteration in progress (MUL or DIV)
//   ready_o         one-cycle pulse, hi_o/lo_o valid from this cycle
//   hi_o, lo_o      result registers, held until the next completion
//   div_by_zero_o   flags a div/divu with zero divisor; cleared on next start
// -----------------------------------------------------------------------------
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic             annul_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_by_zero_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Sign helpers
   // ---------------------------------------------------------------------------
   // Magnitude of a W-bit operand; the most negative value maps to 2^(W-1)
   // read as unsigned, which is exactly what the datapath needs.
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v,
                                              input logic             is_signed);
      logic signed [WIDTH-1:0] sv;
      sv = $signed(v);
      if (is_signed && (sv < 0))
         return ~v + ONE_W;
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v,
                                                 input logic             en);
      return en ? (~v + ONE_W) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v,
                                                    input logic               en);
      return en ? (~v + ONE_2W) : v;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic [WIDTH-1:0]     hi_q,    hi_d;
   logic [WIDTH-1:0]     lo_q,    lo_d;
   logic                 dz_q,    dz_d;

   // Datapath: opnd holds |multiplicand| or |divisor|; work holds the running
   // {upper, multiplier} for multiply or {remainder, dividend/quotient} for divide.
   logic [WIDTH-1:0]     opnd_q,  opnd_d;
   logic [2*WIDTH-1:0]   work_q,  work_d;
   logic                 neg_q,   neg_d;    // product / quotient sign
   logic                 rneg_q,  rneg_d;   // remainder sign

   // ---------------------------------------------------------------------------
   // Operand conditioning at start
   // ---------------------------------------------------------------------------
   logic                 in_signed;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic                 in_neg, in_rneg;
   logic                 b_zero;

   assign in_signed = ~op_i[0];
   assign abs_a     = abs_w(src_a_i, in_signed);
   assign abs_b     = abs_w(src_b_i, in_signed);
   assign in_neg    = in_signed & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
   assign in_rneg   = in_signed & src_a_i[WIDTH-1];
   assign b_zero    = (src_b_i == '0);

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0]   fast_prod;
   assign fast_prod = negate_2w({{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b}, in_neg);
`endif

   // ---------------------------------------------------------------------------
   // One shift-add step: add multiplicand into the upper half when the current
   // multiplier LSB is set, then shift the whole register right by one.
   // ---------------------------------------------------------------------------
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;

   assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                     (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

   // ---------------------------------------------------------------------------
   // One restoring-division step: shift the next dividend bit into the partial
   // remainder, trial-subtract the divisor, keep the difference if it did not
   // borrow. The quotient bit enters at the bottom as dividend bits leave the top.
   // ---------------------------------------------------------------------------
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_trial;
   logic                 div_qbit;
   logic [WIDTH-1:0]     div_rem;
   logic [2*WIDTH-1:0]   div_next;

   assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opnd_q};
   assign div_qbit  = ~div_trial[WIDTH];
   assign div_rem   = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_next  = {div_rem, work_q[WIDTH-2:0], div_qbit};

   logic [2*WIDTH-1:0]   mul_final;
   assign mul_final = negate_2w(mul_next, neg_q);

   // ---------------------------------------------------------------------------
   // Next-state / datapath control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      opnd_d  = opnd_q;
      work_d  = work_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               dz_d   = 1'b0;
               cnt_d  = '0;
               neg_d  = in_neg;
               rneg_d = in_rneg;
               if (op_i[1]) begin
                  if (b_zero) begin
                     hi_d    = src_a_i;
                     lo_d    = '1;
                     dz_d    = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     opnd_d  = abs_b;
                     work_d  = {{WIDTH{1'b0}}, abs_a};
                     state_d = S_DIV;
                  end
               end else begin
`ifdef MDU_FAST_MUL_EN
                  hi_d    = fast_prod[2*WIDTH-1:WIDTH];
                  lo_d    = fast_prod[WIDTH-1:0];
                  state_d = S_DONE;
`else
                  opnd_d  = abs_a;
                  work_d  = {{WIDTH{1'b0}}, abs_b};
                  state_d = S_MUL;
`endif
               end
            end
         end

         S_MUL: begin
            work_d = mul_next;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               hi_d    = mul_final[2*WIDTH-1:WIDTH];
               lo_d    = mul_final[WIDTH-1:0];
               state_d = S_DONE;
            end
         end

         S_DIV: begin
            work_d = div_next;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               lo_d    = negate_w(div_next[WIDTH-1:0], neg_q);
               hi_d    = negate_w(div_next[2*WIDTH-1:WIDTH], rneg_q);
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            // start_i deliberately ignored: a stalled EX may still hold it.
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Flush wins over everything: drop the operation, keep old results.
      if (annul_i) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dz_d    = dz_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

   // Working registers are always rewritten before use, so they need no reset.
   always_ff @(posedge clk) begin
      opnd_q <= opnd_d;
      work_q <= work_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign busy_o        = (state_q == S_MUL) || (state_q == S_DIV);
   assign ready_o       = (state_q == S_DONE) && !annul_i;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter -- self-checking bench for mdu_iter (WIDTH = 32).
// A transaction-level model predicts busy/ready/hi/lo/div_by_zero for every
// cycle from plain 64-bit arithmetic; directed operations add literal checks.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  src_a, src_b;
   logic          annul;
   logic          busy, ready, dz;
   logic [W-1:0]  hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   mdu_iter #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .op_i          (op),
      .src_a_i       (src_a),
      .src_b_i       (src_b),
      .annul_i       (annul),
      .busy_o        (busy),
      .ready_o       (ready),
      .hi_o          (hi),
      .lo_o          (lo),
      .div_by_zero_o (dz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] model_result(input logic [1:0] o,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] res;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      res = '0;
      case (o)
         2'b00: res = sa * sb;
         2'b01: res = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // Transaction model: cycles left busy, pending result, done flag.
   // ---------------------------------------------------------------------------
   logic         m_ok = 1'b0;
   int           m_left = 0;
   logic         m_done = 1'b0;
   logic [31:0]  m_hi = '0, m_lo = '0;
   logic         m_dz = 1'b0;
   logic [63:0]  m_pend = '0;
   logic [63:0]  m_res;

   assign m_res = model_result(op, src_a, src_b);

   always @(posedge clk) begin
      if (rst) begin
         m_ok   <= 1'b1;
         m_left <= 0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_dz   <= 1'b0;
      end else if (annul) begin
         m_left <= 0;
         m_done <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 1) begin
         m_left <= m_left - 1;
      end else if (m_left == 1) begin
         m_left <= 0;
         m_done <= 1'b1;
         m_hi   <= m_pend[63:32];
         m_lo   <= m_pend[31:0];
      end else if (start) begin
         m_dz <= 1'b0;
         if (op[1] && src_b == 0) begin
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
            m_dz   <= 1'b1;
            m_done <= 1'b1;
         end else if (!op[1] && FAST) begin
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
            m_done <= 1'b1;
         end else begin
            m_left <= W;
            m_pend <= m_res;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("busy",  {63'b0, busy},  {63'b0, (m_left != 0)});
         chk("ready", {63'b0, ready}, {63'b0, (m_done && !annul)});
         chk("hi",    {32'b0, hi},    {32'b0, m_hi});
         chk("lo",    {32'b0, lo},    {32'b0, m_lo});
         chk("dz",    {63'b0, dz},    {63'b0, m_dz});
      end
   end

   // ---------------------------------------------------------------------------
   // Issue one operation and wait for ready. lat = cycles from accept to ready,
   // nbusy = cycles with busy high. Ends in the IDLE cycle after DONE.
   // Operand inputs are scrambled after acceptance.
   // ---------------------------------------------------------------------------
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy);
      @(posedge clk); #1;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      lat = 1; nbusy = 0;
      while (!ready && lat < 100) begin
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      if (!ready) chk("ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   int lat, nb, nrdy;
   logic [31:0] mul_lat;
   logic [31:0] mul_busy;

   initial begin
      rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      mul_lat  = FAST ? 32'd1 : 32'd33;
      mul_busy = FAST ? 32'd0 : 32'd32;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",  {63'b0, busy},  64'd0);
      chk("rst_ready", {63'b0, ready}, 64'd0);
      chk("rst_hi",    {32'b0, hi},    64'd0);
      chk("rst_lo",    {32'b0, lo},    64'd0);
      chk("rst_dz",    {63'b0, dz},    64'd0);
      rst = 1'b0;

      // mult -3 * 5
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, nb);
      chk("t1_hi",  {32'b0, hi}, 64'hFFFF_FFFF);
      chk("t1_lo",  {32'b0, lo}, 64'hFFFF_FFF1);
      chk("t1_lat", 64'(lat), {32'b0, mul_lat});

      // multu 0xFFFFFFFF^2
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
      chk("t2_hi",   {32'b0, hi}, 64'hFFFF_FFFE);
      chk("t2_lo",   {32'b0, lo}, 64'h0000_0001);
      chk("t2_busy", 64'(nb), {32'b0, mul_busy});

      // divides
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nb);
      chk("t3a_lo",  {32'b0, lo}, 64'hFFFF_FFFD);
      chk("t3a_hi",  {32'b0, hi}, 64'hFFFF_FFFF);
      chk("t3a_lat", 64'(lat), 64'd33);
      chk("t3a_busy", 64'(nb), 64'd32);
      run_op(2'b11, 32'd7, 32'd2, lat, nb);
      chk("t3b_lo", {32'b0, lo}, 64'd3);
      chk("t3b_hi", {32'b0, hi}, 64'd1);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
      chk("t3c_lo", {32'b0, lo}, 64'h8000_0000);
      chk("t3c_hi", {32'b0, hi}, 64'd0);

      // more sign mixes, model-only plus one literal
      run_op(2'b10, 32'd100, 32'hFFFF_FFF9, lat, nb);     // 100 / -7 -> -14 r 2
      chk("t3d_lo", {32'b0, lo}, 64'hFFFF_FFF2);
      chk("t3d_hi", {32'b0, hi}, 64'd2);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, nb); // 2^62
      chk("t3e_hi", {32'b0, hi}, 64'h4000_0000);
      chk("t3e_lo", {32'b0, lo}, 64'd0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'd1, lat, nb);

      // divide by zero, then next start clears the flag
      run_op(2'b11, 32'h1234_5678, 32'd0, lat, nb);
      chk("t4_lat", 64'(lat), 64'd1);
      chk("t4_dz",  {63'b0, dz}, 64'd1);
      chk("t4_lo",  {32'b0, lo}, 64'hFFFF_FFFF);
      chk("t4_hi",  {32'b0, hi}, 64'h1234_5678);
      run_op(2'b11, 32'd7, 32'd2, lat, nb);
      chk("t4_dz_clr", {63'b0, dz}, 64'd0);

      // annul at cycle 10 of a divide
      @(posedge clk); #1;
      start = 1'b1; op = 2'b10; src_a = 32'h0000_1000; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0;
      chk("t5_busy", {63'b0, busy}, 64'd0);
      nrdy = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready) nrdy++;
         @(posedge clk); #1;
      end
      chk("t5_nrdy", 64'(nrdy), 64'd0);
      chk("t5_hi", {32'b0, hi}, 64'd1);
      chk("t5_lo", {32'b0, lo}, 64'd3);

      // start held through DONE: exactly one pulse
      @(posedge clk); #1;
      start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
      nrdy = 0;
      for (int i = 0; i < 40 && nrdy == 0; i++) begin
         @(posedge clk); #1;
         if (ready) nrdy++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (ready) nrdy++;
         @(posedge clk); #1;
      end
      chk("t6_nrdy", 64'(nrdy), 64'd1);
      chk("t6_busy", {63'b0, busy}, 64'd0);
      chk("t6_lo", {32'b0, lo}, 64'd14);
      chk("t6_hi", {32'b0, hi}, 64'd2);

      // reset at cycle 5 of a divide
      @(posedge clk); #1;
      start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6r_busy",  {63'b0, busy},  64'd0);
      chk("t6r_ready", {63'b0, ready}, 64'd0);
      chk("t6r_hi",    {32'b0, hi},    64'd0);
      chk("t6r_lo",    {32'b0, lo},    64'd0);
      chk("t6r_dz",    {63'b0, dz},    64'd0);
      repeat (40) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
